multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style sequencing FSM that drives a shared-memory, multicycle MIPS datapath. It replaces the single-cycle control path.
- It decodes op/funct from the latched instruction register and steps each instruction through FETCH..writeback.
- It handshakes with a variable-latency unified memory (mem_ready) and flags a bus error if memory times out.
- It supports lw, sw, lb, sb, R-type (add/sub/and/or/slt), beq, bne, addi, andi, ori, lui and j.

Parameters:
TIMEOUT, 255, cycles a memory state waits for mem_ready before aborting (1..2^TW-1)
TW, 8, width of the wait counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
op  input  6  opcode from instruction register
funct  input  6  funct field from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current read/write this cycle
pcen  output  1  PC write enable
iord  output  1  0 = memory address from PC, 1 = from ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  1 = rd, 0 = rt
memtoreg  output  1  1 = register write data from memory data register
regwrite  output  1  register file write enable
alusrca  output  1  0 = PC, 1 = register A
alusrcb  output  2  00 = B, 01 = const 4, 10 = imm, 11 = imm<<2
pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 B<<16
zeroextend  output  1  immediate zero-extended (andi/ori)
disableRA1  output  1  force source A to zero (lui)
bytemode  output  1  byte memory access (lb/sb)
bus_err  output  1  one-cycle pulse on memory timeout
illegal  output  1  one-cycle pulse in DECODE on unsupported op/funct
state  output  4  current state, for debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BRANCHEX=8, ITYPEEX=9, ITYPEWB=10, JEX=11.
- Reset (reset=0): state=FETCH, wait counter=0, bus_err=0, illegal=0. pcen, irwrite, memwrite and regwrite are forced 0 for as long as reset=0; other outputs show FETCH decode. Reset mid-instruction abandons the instruction with no further writes.
- Outputs are combinational from state, op, funct, zero and mem_ready. Any output not listed for a state is 0. alucontrol defaults to ADD.
- FETCH: iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00. While mem_ready=0: stay in FETCH. When mem_ready=1: irwrite=1, pcen=1, go to DECODE.
- DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut). Next state by op:
  - lw/sw/lb/sb -> MEMADR
  - 000000 with legal funct -> RTYPEEX
  - beq/bne -> BRANCHEX
  - addi/andi/ori/lui -> ITYPEEX
  - j -> JEX
  - anything else -> illegal=1, go to FETCH (instruction acts as a nop).
- MEMADR: alusrca=1, alusrcb=10, ADD. Loads go to MEMRD, stores go to MEMWR.
- MEMRD: iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1, held until the cycle mem_ready=1, then FETCH.
- bytemode=1 in MEMADR/MEMRD/MEMWB/MEMWR when op is lb(100000) or sb(101000).
- RTYPEEX: alusrca=1, alusrcb=00. Funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Then RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, alucontrol as in RTYPEEX, then FETCH.
- BRANCHEX: alusrca=1, alusrcb=00, SUB, pcsrc=01. pcen=zero for beq(000100), pcen=~zero for bne(000101). Then FETCH.
- ITYPEEX and ITYPEWB:
  - alusrca=1, alusrcb=10.
  - addi(001000) ADD; andi(001100) AND with zeroextend=1; ori(001101) OR with zeroextend=1; lui(001111) B<<16 with disableRA1=1 and zeroextend=1.
  - ITYPEWB additionally drives regdst=0, regwrite=1, then FETCH.
- JEX: pcsrc=10, pcen=1, then FETCH.
- Wait counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0. It clears on any state change and on mem_ready=1.
  - If the counter reaches TIMEOUT with mem_ready still 0: bus_err=1 for one cycle, go to FETCH, and suppress all writes that cycle.
  - A FETCH timeout re-fetches the same PC.
  - mem_ready=1 on the timeout cycle wins: normal completion, no bus_err.
- Instruction latency with zero wait states:
  - lw/lb: 5 cycles
  - sw/sb, R-type, I-type: 4 cycles
  - branch, j: 3 cycles
  - illegal: 2 cycles

Test Plan:
- Reset and fetch: reset low with mem_ready=1 -> state=0, pcen=irwrite=0. Release reset -> pcen=irwrite=1 in the next cycle, state=1.
- lw, zero wait: op=100011 -> state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. Same op with 3 wait cycles in MEMRD -> state 3 held for 4 cycles.
- Branches: beq with zero=1 -> pcen=1, pcsrc=01 in state 8. bne with zero=1 -> pcen=0.
- I-type: ori -> alucontrol=0001, zeroextend=1 in states 9 and 10, regdst=0, regwrite=1 in 10. lui -> alucontrol=1000, disableRA1=1.
- Timeout (TIMEOUT=4): mem_ready held 0 in MEMWR -> memwrite=1 for 4 cycles, bus_err pulses, state=0, no regwrite. Separately, mem_ready=1 exactly on cycle 4 -> no bus_err.
- Illegal: op=111111 -> illegal=1 in DECODE, next state=0, no write enables asserted. Reset asserted in state 3 -> immediate state=0, regwrite never asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore-style sequencing controller for a shared-memory multicycle MIPS datapath.
// Steps each instruction from FETCH through writeback, with a memory-wait timeout.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       zeroextend,
  output logic       disableRA1,
  output logic       bytemode,
  output logic       bus_err,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPEEX  = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCHEX = 4'd8,
    ITYPEEX  = 4'd9,
    ITYPEWB  = 4'd10,
    JEX      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  state_t        cur, nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          waiting, timeout;

  logic is_load, is_store, is_branch, is_itype, rtype_ok;
  logic [3:0] r_alu, i_alu;
  logic       i_zx, i_dra;

  // Unsuppressed control values, before reset gating
  logic pcen_c, memwrite_c, irwrite_c, regwrite_c, berr_c;

  assign is_load   = (op == OP_LW) || (op == OP_LB);
  assign is_store  = (op == OP_SW) || (op == OP_SB);
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign is_itype  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LUI);

  always_comb begin
    rtype_ok = 1'b1;
    r_alu    = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = ALU_ADD;
    i_zx  = 1'b0;
    i_dra = 1'b0;
    case (op)
      OP_ANDI: begin i_alu = ALU_AND; i_zx = 1'b1; end
      OP_ORI:  begin i_alu = ALU_OR;  i_zx = 1'b1; end
      OP_LUI:  begin i_alu = ALU_LUI; i_zx = 1'b1; i_dra = 1'b1; end
      default: ;
    endcase
  end

  assign waiting = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  assign timeout = waiting && !mem_ready && (cnt == TW'(TIMEOUT));

  always_comb begin
    nxt        = cur;
    pcen_c     = 1'b0;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    zeroextend = 1'b0;
    disableRA1 = 1'b0;
    berr_c     = 1'b0;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          nxt       = DECODE;
        end else if (timeout) begin
          // Staying in FETCH re-issues the same PC on the next attempt
          berr_c = 1'b1;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        if (is_load || is_store)               nxt = MEMADR;
        else if (op == OP_RTYPE && rtype_ok)   nxt = RTYPEEX;
        else if (is_branch)                    nxt = BRANCHEX;
        else if (is_itype)                     nxt = ITYPEEX;
        else if (op == OP_J)                   nxt = JEX;
        else begin
          illegal = 1'b1;
          nxt     = FETCH;
        end
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = is_load ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) nxt = MEMWB;
        else if (timeout) begin
          berr_c = 1'b1;
          nxt    = FETCH;
        end
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        nxt        = FETCH;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        if (mem_ready) nxt = FETCH;
        else if (timeout) begin
          memwrite_c = 1'b0;
          berr_c     = 1'b1;
          nxt        = FETCH;
        end
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = r_alu;
        nxt        = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        alucontrol = r_alu;
        nxt        = FETCH;
      end
      BRANCHEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen_c     = (op == OP_BEQ) ? zero : ((op == OP_BNE) ? ~zero : 1'b0);
        nxt        = FETCH;
      end
      ITYPEEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = i_alu;
        zeroextend = i_zx;
        disableRA1 = i_dra;
        nxt        = ITYPEWB;
      end
      ITYPEWB: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = i_alu;
        zeroextend = i_zx;
        disableRA1 = i_dra;
        regwrite_c = 1'b1;
        nxt        = FETCH;
      end
      JEX: begin
        pcsrc  = 2'b10;
        pcen_c = 1'b1;
        nxt    = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  assign bytemode = ((cur == MEMADR) || (cur == MEMRD) || (cur == MEMWB) || (cur == MEMWR))
                    && ((op == OP_LB) || (op == OP_SB));

  // Write strobes stay low while reset is held, independent of the clock
  assign pcen     = pcen_c & reset;
  assign irwrite  = irwrite_c & reset;
  assign memwrite = memwrite_c & reset;
  assign regwrite = regwrite_c & reset;
  assign bus_err  = berr_c & reset;
  assign state    = cur;

  always_comb begin
    cnt_nxt = '0;
    if (waiting && !mem_ready && !timeout && nxt == cur)
      cnt_nxt = cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench for multicycle_controller: an instruction-level model queues the
// expected per-cycle control word; a negedge monitor pops and compares.
module tb_multicycle_controller;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;
  logic       zeroextend, disableRA1, bytemode, bus_err, illegal;
  logic [3:0] state;

  multicycle_controller #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .zeroextend(zeroextend), .disableRA1(disableRA1),
    .bytemode(bytemode), .bus_err(bus_err), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alu;
    logic       zx, dra, byt, berr, ill;
    logic [3:0] st;
  } vec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, LB = 6'b100000, SB = 6'b101000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, LUI = 6'b001111;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_LUI = 4'b1000;

  vec_t        exp_q[$];
  vec_t        act, mon_e;
  int unsigned tests = 0, fails = 0;

  assign act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, zeroextend, disableRA1, bytemode, bus_err,
                illegal, state};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (act !== mon_e) begin
        fails++;
        $display("FAIL ctrl t=%0t op=%b: got %h (state %0d) expected %h (state %0d)",
                 $time, op, act, act.st, mon_e, mon_e.st);
      end
    end
  end

  function automatic vec_t base(input logic [3:0] st);
    vec_t v;
    v = '0;
    v.alu = A_ADD;
    v.st = st;
    return v;
  endfunction

  // R-type funct table; returns 1 in legal when funct is supported
  function automatic logic [3:0] r_alu(input logic [5:0] f, output logic legal);
    legal = 1'b1;
    case (f)
      6'b100000: return A_ADD;
      6'b100010: return A_SUB;
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b101010: return A_SLT;
      default: begin legal = 1'b0; return A_ADD; end
    endcase
  endfunction

  task automatic cyc(input vec_t e, input logic mr);
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // w not-ready cycles before ready; beyond TO the attempt times out and is retried
  task automatic fetch(input int unsigned w);
    vec_t e, t;
    e = base(4'd0);
    e.alusrcb = 2'b01;
    for (int unsigned i = 0; i < w && i < TO; i++) cyc(e, 1'b0);
    if (w > TO) begin
      t = e;
      t.berr = 1'b1;
      cyc(t, 1'b0);
    end
    e.pcen = 1'b1;
    e.irwrite = 1'b1;
    cyc(e, 1'b1);
  endtask

  task automatic memwait(input vec_t e, input int unsigned w, output logic ok);
    vec_t t;
    for (int unsigned i = 0; i < w && i < TO; i++) cyc(e, 1'b0);
    if (w > TO) begin
      t = e;
      t.memwrite = 1'b0;
      t.berr = 1'b1;
      cyc(t, 1'b0);
      ok = 1'b0;
    end else begin
      cyc(e, 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int unsigned wf, input int unsigned wm);
    vec_t d, e;
    logic ok, rlegal, byt;
    logic [3:0] ra;
    op = o; funct = f; zero = z;
    fetch(wf);
    d = base(4'd1);
    d.alusrcb = 2'b11;
    byt = (o == LB) || (o == SB);
    ra = r_alu(f, rlegal);
    if (o == LW || o == LB || o == SW || o == SB) begin
      cyc(d, rnd());
      e = base(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.byt = byt;
      cyc(e, rnd());
      if (o == LW || o == LB) begin
        e = base(4'd3); e.iord = 1'b1; e.byt = byt;
        memwait(e, wm, ok);
        if (ok) begin
          e = base(4'd4); e.memtoreg = 1'b1; e.regwrite = 1'b1; e.byt = byt;
          cyc(e, rnd());
        end
      end else begin
        e = base(4'd5); e.iord = 1'b1; e.memwrite = 1'b1; e.byt = byt;
        memwait(e, wm, ok);
      end
    end else if (o == 6'b000000 && rlegal) begin
      cyc(d, rnd());
      e = base(4'd6); e.alusrca = 1'b1; e.alu = ra;
      cyc(e, rnd());
      e = base(4'd7); e.regdst = 1'b1; e.regwrite = 1'b1; e.alu = ra;
      cyc(e, rnd());
    end else if (o == BEQ || o == BNE) begin
      cyc(d, rnd());
      e = base(4'd8); e.alusrca = 1'b1; e.alu = A_SUB; e.pcsrc = 2'b01;
      e.pcen = (o == BEQ) ? z : ~z;
      cyc(e, rnd());
    end else if (o == ADDI || o == ANDI || o == ORI || o == LUI) begin
      cyc(d, rnd());
      e = base(4'd9); e.alusrca = 1'b1; e.alusrcb = 2'b10;
      e.alu = (o == ANDI) ? A_AND : (o == ORI) ? A_OR : (o == LUI) ? A_LUI : A_ADD;
      e.zx = (o != ADDI);
      e.dra = (o == LUI);
      cyc(e, rnd());
      e.st = 4'd10; e.regwrite = 1'b1;
      cyc(e, rnd());
    end else if (o == J) begin
      cyc(d, rnd());
      e = base(4'd11); e.pcsrc = 2'b10; e.pcen = 1'b1;
      cyc(e, rnd());
    end else begin
      d.ill = 1'b1;
      cyc(d, rnd());
    end
  endtask

  task automatic hold_reset(input int unsigned n);
    vec_t e;
    reset = 1'b0;
    e = base(4'd0);
    e.alusrcb = 2'b01;
    for (int unsigned i = 0; i < n; i++) cyc(e, 1'b1);
    reset = 1'b1;
  endtask

  logic [5:0] ops [14];
  logic [5:0] rf  [5];

  initial begin
    vec_t e;
    logic [5:0] o, f;
    int unsigned wf, wm;
    ops = '{LW, SW, LB, SB, BEQ, BNE, J, ADDI, ANDI, ORI, LUI, 6'b000000, 6'b000000, 6'b111111};
    rf  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    @(posedge clk);
    #1;
    hold_reset(3);

    // Directed cases
    do_instr(LW, 6'b0, 1'b0, 0, 0);
    do_instr(LW, 6'b0, 1'b0, 0, 3);
    do_instr(BEQ, 6'b0, 1'b1, 0, 0);
    do_instr(BNE, 6'b0, 1'b1, 0, 0);
    do_instr(BEQ, 6'b0, 1'b0, 0, 0);
    do_instr(ORI, 6'b0, 1'b0, 0, 0);
    do_instr(LUI, 6'b0, 1'b0, 0, 0);
    do_instr(SW, 6'b0, 1'b0, 0, 7);
    do_instr(SW, 6'b0, 1'b0, 0, TO);
    do_instr(LB, 6'b0, 1'b0, 0, TO + 1);
    do_instr(SB, 6'b0, 1'b0, TO + 2, 1);
    do_instr(6'b000000, 6'b101010, 1'b0, TO, 0);
    do_instr(6'b000000, 6'b000111, 1'b0, 0, 0);
    do_instr(6'b111111, 6'b0, 1'b0, 0, 0);
    do_instr(J, 6'b0, 1'b0, 0, 0);

    // Reset while waiting in MEMRD abandons the load without a register write
    op = LW; funct = '0;
    fetch(0);
    e = base(4'd1); e.alusrcb = 2'b11; cyc(e, 1'b0);
    e = base(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10; cyc(e, 1'b0);
    e = base(4'd3); e.iord = 1'b1; cyc(e, 1'b0);
    hold_reset(2);
    do_instr(ADDI, 6'b0, 1'b0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      o = ops[$urandom_range(0, 13)];
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : rf[$urandom_range(0, 4)];
      wf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : 0;
      wm = ($urandom_range(0, 1) == 0) ? $urandom_range(0, TO + 2) : 0;
      do_instr(o, f, 1'($urandom), wf, wm);
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
